// File: rtl/pwm_capture_if.sv
// PWM capture bus: raw PWM pin in, duty/period measurement and stuck status out.
// master = the measuring block, slave = the consumer that drives the pin and reads results.
interface pwm_capture_if #(
  parameter int CNT_W = 8
);
  logic             pwm_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output duty,
    output period,
    output valid,
    output stuck,
    output stuck_level
  );

  modport slave (
    output pwm_in,
    input  duty,
    input  period,
    input  valid,
    input  stuck,
    input  stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM high-time/period meter with stuck-line detection; valid follows a sampled rise by 3 cycles.
// Optional glitch filter (+1 cycle) enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             sync1;
  logic             sync2;
  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;
  logic             at_max;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;

  logic meas;
  logic latch_hi;
  logic timeout;
  logic cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Level is accepted only once the incoming and current synchronizer samples agree.
  logic s_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 1'b0;
    end else if (sync1 == sync2) begin
      s_q <= sync2;
    end
  end
  assign s = s_q;
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign at_max = (cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (rise)        state_nxt = HIGH;
        else if (fall)   state_nxt = LOW;
        else if (at_max) state_nxt = IDLE;
      end
      LOW: begin
        if (rise)        state_nxt = HIGH;
        else if (at_max) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An edge coinciding with cnt == MAX wins over the timeout, so period = MAX is measurable.
  always_comb begin
    meas     = 1'b0;
    latch_hi = 1'b0;
    timeout  = 1'b0;
    cnt_inc  = 1'b0;
    if (state != IDLE) begin
      timeout = at_max & ~rise & ~fall;
      cnt_inc = ~at_max;
    end
    if (state == LOW)  meas     = rise;
    if (state == HIGH) latch_hi = fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      hi_cnt          <= '0;
      bus.duty        <= '0;
      bus.period      <= '0;
      bus.valid       <= 1'b0;
      bus.stuck       <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      bus.valid <= meas;
      if (rise) begin
        cnt <= ONE;
      end else if (cnt_inc) begin
        cnt <= cnt + ONE;
      end
      if (latch_hi) begin
        hi_cnt <= cnt;
      end
      if (meas) begin
        bus.duty   <= hi_cnt;
        bus.period <= cnt;
      end
      if (rise) begin
        bus.stuck <= 1'b0;
      end else if (timeout) begin
        bus.stuck       <= 1'b1;
        bus.stuck_level <= s;
      end
    end
  end

endmodule
